sam_core: RTL and testbench



---
 rtl/sam_pkg.sv | 27 ++
 rtl/sam_if.sv | 23 ++
 rtl/sam_alu.sv | 29 ++
 rtl/sam_core.sv | 138 +++++++++++++
 tb/tb_sam_core.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sam_pkg.sv
// Shared definitions for the SAM single-accumulator core: opcodes, FSM states,
// bus direction encoding and ALU operation select.
package sam_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        MEM_WR,
        EXEC
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

endpackage

// File: rtl/sam_if.sv
// Memory-side req/wait handshake bundle. The core drives it through the
// master modport; the memory model answers through the slave modport.
interface sam_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wait;

    modport master (
        output mem_addr, mem_req, mem_rw, mem_wdata,
        input  mem_rdata, mem_wait
    );

    modport slave (
        input  mem_addr, mem_req, mem_rw, mem_wdata,
        output mem_rdata, mem_wait
    );
endinterface

// File: rtl/sam_alu.sv
// Combinational accumulator ALU: pass-B, add or subtract, with a signed
// overflow indication for the arithmetic operations.
module sam_alu
    import sam_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);
    always_comb begin
        y   = b;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = a + b;
                ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                y   = a - b;
                ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sam_core.sv
// SAM accumulator core: fetch/decode/memory/execute microsequencer over a
// req/wait memory port. Define SAM_SUB_EN to turn ADD with operand MSB set into SUB.
module sam_core
    import sam_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    sam_if.master             mem,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] ac_o,
    output logic              ovf_o
);
    localparam int OPD_W = DATA_W - 2;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ac_q, ac_d, ir_q, ir_d, mbr_q, mbr_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        opcode;
    logic              sub_sel;
    logic [OPD_W-1:0]  opd_raw, opd_eff;
    logic [ADDR_W-1:0] opd_addr, brn_addr;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;

    assign opcode  = ir_q[DATA_W-1 -: 2];
    assign opd_raw = ir_q[OPD_W-1:0];

`ifdef SAM_SUB_EN
    // Operand MSB doubles as the subtract selector and is not part of the address.
    assign sub_sel = (opcode == OP_ADD) && ir_q[OPD_W-1];
    assign opd_eff = sub_sel ? {1'b0, opd_raw[OPD_W-2:0]} : opd_raw;
`else
    assign sub_sel = 1'b0;
    assign opd_eff = opd_raw;
`endif

    if (OPD_W >= ADDR_W) begin : g_trunc
        assign opd_addr = opd_eff[ADDR_W-1:0];
        assign brn_addr = opd_raw[ADDR_W-1:0];
    end else begin : g_ext
        assign opd_addr = {{(ADDR_W-OPD_W){1'b0}}, opd_eff};
        assign brn_addr = {{(ADDR_W-OPD_W){1'b0}}, opd_raw};
    end

    always_comb begin
        alu_op = ALU_PASS;
        if (opcode == OP_ADD) alu_op = sub_sel ? ALU_SUB : ALU_ADD;
    end

    sam_alu #(.DATA_W(DATA_W)) u_alu (
        .op  (alu_op),
        .a   (ac_q),
        .b   (mbr_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        ovf_d   = ovf_q;
        case (state_q)
            FETCH: if (!mem.mem_wait) begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + PC_INC;
                state_d = DECODE;
            end
            DECODE: begin
                mar_d = opd_addr;
                case (opcode)
                    OP_LOAD, OP_ADD: state_d = MEM_RD;
                    OP_STORE:        state_d = MEM_WR;
                    default: begin
                        if (ac_q[DATA_W-1]) pc_d = brn_addr;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM_RD: if (!mem.mem_wait) begin
                mbr_d   = mem.mem_rdata;
                state_d = EXEC;
            end
            MEM_WR: if (!mem.mem_wait) state_d = FETCH;
            EXEC: begin
                ac_d    = alu_y;
                ovf_d   = ovf_q | (alu_op != ALU_PASS && alu_ovf);
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RST;
            ac_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mbr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Bus outputs depend only on state registers, so they hold while mem_wait=1.
    always_comb begin
        mem.mem_req   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        mem.mem_rw    = (state_q == MEM_WR) ? RW_WRITE : RW_READ;
        mem.mem_addr  = (state_q == MEM_RD || state_q == MEM_WR) ? mar_q : pc_q;
        mem.mem_wdata = (state_q == MEM_WR) ? ac_q : '0;
    end

    assign pc_o  = pc_q;
    assign ac_o  = ac_q;
    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_sam_core.sv
// Scoreboard bench for sam_core: an instruction-level model predicts every bus
// transfer and the architectural state seen at each fetch.
module tb_sam_core;
    logic        clk;
    logic        reset;
    logic [15:0] pc_o, ac_o;
    logic        ovf_o;

    sam_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

    sam_core #(.DATA_W(16), .ADDR_W(16), .PC_STEP(2), .RESET_PC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (mem_bus),
        .pc_o  (pc_o),
        .ac_o  (ac_o),
        .ovf_o (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_arr [0:65535];
    logic [15:0] mdl     [0:65535];
    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];

    typedef struct {
        bit          fetch;
        bit          rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ac;
        bit          ovf;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int wait_pct = 0, hold_n = 0;
    logic [15:0] hold_addr = 16'hFFFF;
    bit mon_en = 0, stall_seen = 0;
    int cyc, last_cyc, waits;
    logic [15:0] h_addr, h_wdata;
    logic h_rw;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Wait-state generator: directed hold on one address, otherwise random.
    initial begin
        mem_bus.mem_wait = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_bus.mem_req && mem_bus.mem_addr == hold_addr && hold_n > 0) begin
                mem_bus.mem_wait = 1'b1;
                hold_n--;
            end else begin
                mem_bus.mem_wait = (wait_pct != 0) && ($urandom_range(99) < wait_pct);
            end
        end
    end

    // Memory write side, committed mid-cycle of the completing transfer.
    initial forever begin
        @(negedge clk);
        if (!reset && mem_bus.mem_req && !mem_bus.mem_wait && mem_bus.mem_rw == 1'b0)
            mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
    end

    // Monitor: pops one expectation per completed transfer.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            cyc++;
            if (mem_bus.mem_req) begin
                if (stall_seen) begin
                    chk("hold_addr", mem_bus.mem_addr, h_addr);
                    chk("hold_rw", mem_bus.mem_rw, h_rw);
                    chk("hold_wdata", mem_bus.mem_wdata, h_wdata);
                end
                if (mem_bus.mem_wait) begin
                    waits++;
                    stall_seen = 1;
                    h_addr = mem_bus.mem_addr;
                    h_rw = mem_bus.mem_rw;
                    h_wdata = mem_bus.mem_wdata;
                end else begin
                    stall_seen = 0;
                    if (exp_q.size() == 0) begin
                        chk("extra_xfer", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(e.fetch ? "fetch_addr" : "data_addr", mem_bus.mem_addr, e.addr);
                        chk("xfer_rw", mem_bus.mem_rw, e.rw);
                        if (!e.rw) chk("wdata", mem_bus.mem_wdata, e.wdata);
                        if (e.fetch) begin
                            chk("pc", pc_o, e.addr);
                            chk("ac", ac_o, e.ac);
                            chk("ovf", ovf_o, e.ovf);
                            if (e.lat >= 0) chk("latency", cyc - last_cyc - waits, e.lat);
                            last_cyc = cyc;
                            waits = 0;
                        end
                    end
                end
            end else if (stall_seen) begin
                chk("req_dropped", 0, 1);
                stall_seen = 0;
            end
        end
    end

    // Instruction-level reference: executes the program on its own memory copy.
    task automatic build_expect(input int n);
        logic [15:0] pc, ac, ir, opd, b;
        bit ovf;
        int lat, s;
        pc = 0; ac = 0; ovf = 0; lat = -1;
        for (int a = 0; a < 65536; a++) mdl[a] = mem_arr[a];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1, 1, pc, 16'h0, ac, ovf, lat});
            ir  = mdl[pc];
            pc  = pc + 16'd2;
            opd = {2'b00, ir[13:0]};
            case (ir[15:14])
                2'd0: begin
                    exp_q.push_back('{0, 1, opd, 16'h0, 16'h0, 0, 0});
                    ac = mdl[opd]; lat = 4;
                end
                2'd1: begin
                    exp_q.push_back('{0, 0, opd, ac, 16'h0, 0, 0});
                    mdl[opd] = ac; lat = 3;
                end
                2'd2: begin
`ifdef SAM_SUB_EN
                    if (ir[13]) begin
                        opd[13] = 1'b0;
                        b = mdl[opd];
                        s = int'($signed(ac)) - int'($signed(b));
                    end else begin
                        b = mdl[opd];
                        s = int'($signed(ac)) + int'($signed(b));
                    end
`else
                    b = mdl[opd];
                    s = int'($signed(ac)) + int'($signed(b));
`endif
                    exp_q.push_back('{0, 1, opd, 16'h0, 16'h0, 0, 0});
                    if (s > 32767 || s < -32768) ovf = 1;
                    ac = 16'(s); lat = 4;
                end
                default: begin
                    if (ac[15]) pc = opd;
                    lat = 2;
                end
            endcase
        end
        exp_q.push_back('{1, 1, pc, 16'h0, ac, ovf, lat});
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) mem_arr[a] = 16'h0;
    endtask

    task automatic run_test(input string nm, input int n, input int wpct);
        int k;
        mon_en = 0;
        reset = 1;
        wait_pct = wpct;
        exp_q.delete();
        build_expect(n);
        repeat (2) @(posedge clk);
        cyc = 0; last_cyc = 0; waits = 0; stall_seen = 0;
        #2;
        reset = 0;
        mon_en = 1;
        k = 0;
        while (exp_q.size() > 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() > 0) chk({nm, "_timeout"}, exp_q.size(), 0);
        mon_en = 0;
        reset = 1;
        hold_n = 0;
        exp_q.delete();
    endtask

    initial begin
        int k;
        reset = 1;
        clear_mem();
        @(negedge clk);
        chk("rst_req", mem_bus.mem_req, 1);
        chk("rst_rw", mem_bus.mem_rw, 1);
        chk("rst_addr", mem_bus.mem_addr, 0);
        chk("rst_wdata", mem_bus.mem_wdata, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_ac", ac_o, 0);
        chk("rst_ovf", ovf_o, 0);

        // LOAD 0x10, ADD 0x12, LOAD 0
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[2] = 16'h8012;
        mem_arr[16'h10] = 16'h0003; mem_arr[16'h12] = 16'h0004;
        run_test("load_add", 3, 0);

        // STORE with three wait cycles on the write
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[2] = 16'h4020; mem_arr[16'h10] = 16'h1234;
        hold_addr = 16'h0020; hold_n = 3;
        run_test("store_wait", 3, 0);
        chk("store_mem", mem_arr[16'h20], 16'h1234);

        // BRN taken and not taken
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[2] = 16'hC040; mem_arr[16'h10] = 16'h8000;
        run_test("brn_taken", 3, 0);
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[2] = 16'hC040; mem_arr[16'h10] = 16'h7FFF;
        run_test("brn_not", 3, 0);

        // Overflow stays sticky through a later LOAD
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[2] = 16'h8012; mem_arr[4] = 16'h0000;
        mem_arr[16'h10] = 16'h7FFF; mem_arr[16'h12] = 16'h0001;
        run_test("ovf", 4, 0);

        // Reset during a MEM_RD wait
        clear_mem();
        mem_arr[0] = 16'h0010; mem_arr[16'h10] = 16'h0003;
        hold_addr = 16'h0010; hold_n = 1000; wait_pct = 0;
        @(posedge clk); #2; reset = 0;
        k = 0;
        while (!(mem_bus.mem_req && mem_bus.mem_addr == 16'h0010 && mem_bus.mem_wait) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_reached", k < 50, 1);
        repeat (2) @(negedge clk);
        #2; reset = 1; #1;
        chk("midrst_req", mem_bus.mem_req, 1);
        chk("midrst_addr", mem_bus.mem_addr, 0);
        chk("midrst_rw", mem_bus.mem_rw, 1);
        chk("midrst_pc", pc_o, 0);
        chk("midrst_ac", ac_o, 0);
        hold_n = 0;
        hold_addr = 16'hFFFF;

        // Random programs with random wait states
        for (int t = 0; t < 4; t++) begin
            clear_mem();
            for (int a = 0; a < 256; a++)
                mem_arr[a] = {2'($urandom), 6'b0, 8'($urandom)};
            run_test("random", 40, (t == 0) ? 0 : 30);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
